// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared channel FSM state encoding for mem_controller_rr
package memctrl_pkg;
  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } ctrl_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant for one channel, searching from the shared rr_ptr
// Ports: clk, reset (async, active-high); en_i channel idle; req_i requests; busy_i consumers already taken;
//        upd_i/nxt_i shared pointer update; gnt_o one-hot grant; idx_o granted index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         busy_i,
  input  logic                 upd_i,
  input  logic [$clog2(N)-1:0] nxt_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] rr_ptr_q;
  logic found;
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(rr_ptr_q) + k) % N;
      if (en_i && !found && req_i[j] && !busy_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = PW'(j);
      end
    end
  end
  // every instance receives the same update, so all channels search from one common pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else if (upd_i) rr_ptr_q <= nxt_i;
  end
endmodule

// File: rtl/mem_controller_rr.sv
// mem_controller_rr: N consumers share NUM_CHANNELS memory channels with round-robin arbitration
// Ports: clk, reset (async, active-high); consumer_read_*/consumer_write_* valid/ready requester side;
//        mem_read_*/mem_write_* valid/ready memory side, one lane per channel.
// Optional: define MEMCTRL_STATS_EN to add stat_reads, stat_writes, stat_stall_cycles counters.
module mem_controller_rr
  import memctrl_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1,
  parameter int DATA_READ_NUM = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_CONSUMERS-1:0]                               consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]                consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                               consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_READ_NUM*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                               consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]                consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]                consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                               consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                                mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]                 mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                                mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_READ_NUM*DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                                mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]                 mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]                 mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                                mem_write_ready
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [31:0]                                            stat_reads,
  output logic [31:0]                                            stat_writes,
  output logic [31:0]                                            stat_stall_cycles
`endif
);
  localparam int PW = $clog2(NUM_CONSUMERS);
  ctrl_state_t state_q [NUM_CHANNELS];
  logic [PW-1:0] cons_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mrv_q, mwv_q;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mra_q, mwa_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mwd_q;
  logic [NUM_CONSUMERS-1:0] crr_q, cwr_q;
  logic [NUM_CONSUMERS-1:0][DATA_READ_NUM*DATA_BITS-1:0] crd_q;
  logic [NUM_CONSUMERS-1:0] wr_req, req, served;
  logic [NUM_CONSUMERS-1:0] gnt [NUM_CHANNELS];
  logic [PW-1:0] idx [NUM_CHANNELS];
  logic upd;
  logic [PW-1:0] nxt;
  assign wr_req = WRITE_ENABLE != 0 ? consumer_write_valid : '0;
  assign req = consumer_read_valid | wr_req;
  always_comb begin
    served = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (state_q[c] != IDLE) served[cons_q[c]] = 1'b1;
  end
  // the highest granting channel holds the last granted consumer
  always_comb begin
    upd = 1'b0;
    nxt = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (|gnt[c]) begin
        upd = 1'b1;
        nxt = int'(idx[c]) == NUM_CONSUMERS - 1 ? '0 : idx[c] + 1'b1;
      end
  end
  // each channel sees consumers taken by active channels and by lower channels granting this cycle
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] busy_in, busy_out, g;
    logic [PW-1:0] i;
    if (c == 0) begin : g_first
      assign busy_in = served;
    end else begin : g_next
      assign busy_in = g_ch[c-1].busy_out;
    end
    rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .en_i   (state_q[c] == IDLE),
      .req_i  (req),
      .busy_i (busy_in),
      .upd_i  (upd),
      .nxt_i  (nxt),
      .gnt_o  (g),
      .idx_o  (i)
    );
    assign busy_out = busy_in | g;
    assign gnt[c] = g;
    assign idx[c] = i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cons_q[c] <= '0;
      end
      mrv_q <= '0;
      mwv_q <= '0;
      mra_q <= '0;
      mwa_q <= '0;
      mwd_q <= '0;
      crr_q <= '0;
      cwr_q <= '0;
      crd_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state_q[c])
          IDLE: if (|gnt[c]) begin
            cons_q[c] <= idx[c];
            if (consumer_read_valid[idx[c]]) begin
              state_q[c] <= READ_WAITING;
              mrv_q[c] <= 1'b1;
              mra_q[c] <= consumer_read_address[idx[c]];
            end else begin
              state_q[c] <= WRITE_WAITING;
              mwv_q[c] <= 1'b1;
              mwa_q[c] <= consumer_write_address[idx[c]];
              mwd_q[c] <= consumer_write_data[idx[c]];
            end
          end
          READ_WAITING: if (mem_read_ready[c]) begin
            state_q[c] <= READ_RELAYING;
            mrv_q[c] <= 1'b0;
            crr_q[cons_q[c]] <= 1'b1;
            crd_q[cons_q[c]] <= mem_read_data[c];
          end
          WRITE_WAITING: if (mem_write_ready[c]) begin
            state_q[c] <= WRITE_RELAYING;
            mwv_q[c] <= 1'b0;
            cwr_q[cons_q[c]] <= 1'b1;
          end
          READ_RELAYING: if (!consumer_read_valid[cons_q[c]]) begin
            state_q[c] <= IDLE;
            crr_q[cons_q[c]] <= 1'b0;
          end
          WRITE_RELAYING: if (!consumer_write_valid[cons_q[c]]) begin
            state_q[c] <= IDLE;
            cwr_q[cons_q[c]] <= 1'b0;
          end
          default: state_q[c] <= IDLE;
        endcase
      end
    end
  end
  assign consumer_read_ready  = crr_q;
  assign consumer_read_data   = crd_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign consumer_write_ready = WRITE_ENABLE != 0 ? cwr_q : '0;
  assign mem_write_valid      = WRITE_ENABLE != 0 ? mwv_q : '0;
  assign mem_write_address    = WRITE_ENABLE != 0 ? mwa_q : '0;
  assign mem_write_data       = WRITE_ENABLE != 0 ? mwd_q : '0;
`ifdef MEMCTRL_STATS_EN
  logic [31:0] reads_q, writes_q, stall_q, rd_n, wr_n;
  logic [NUM_CHANNELS-1:0] idle;
  always_comb begin
    rd_n = '0;
    wr_n = '0;
    idle = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      idle[c] = state_q[c] == IDLE;
      rd_n = rd_n + 32'(state_q[c] == READ_RELAYING && !consumer_read_valid[cons_q[c]]);
      wr_n = wr_n + 32'(state_q[c] == WRITE_RELAYING && !consumer_write_valid[cons_q[c]]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reads_q <= '0;
      writes_q <= '0;
      stall_q <= '0;
    end else begin
      reads_q <= reads_q + rd_n;
      writes_q <= writes_q + wr_n;
      stall_q <= stall_q + 32'(|(req & ~served) && !(|idle));
    end
  end
  assign stat_reads        = reads_q;
  assign stat_writes       = writes_q;
  assign stat_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mem_controller_rr.sv
// tb_mem_controller_rr: directed checks of arbitration, handshakes, multi-channel, write disable and reset
module tb_mem_controller_rr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] rv = '0, wv = '0;
  logic [3:0][7:0] ra = '0, wa = '0;
  logic [3:0][15:0] wd = '0;
  logic [0:0] m0_rr = '0, m0_wr = '0;
  logic [0:0][15:0] m0_rd = '0;
  logic [1:0] m1_rr = '0, m1_wr = '0;
  logic [1:0][15:0] m1_rd = '0;
  logic [3:0] u0_crr, u0_cwr, u1_crr, u1_cwr, u2_crr, u2_cwr;
  logic [3:0][15:0] u0_crd, u1_crd, u2_crd;
  logic [0:0] u0_mrv, u0_mwv, u2_mrv, u2_mwv;
  logic [0:0][7:0] u0_mra, u0_mwa, u2_mra, u2_mwa;
  logic [0:0][15:0] u0_mwd, u2_mwd;
  logic [1:0] u1_mrv, u1_mwv;
  logic [1:0][7:0] u1_mra, u1_mwa;
  logic [1:0][15:0] u1_mwd;
  logic seen_mwv, seen_cwr;
  int e;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_controller_rr u0 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra), .consumer_read_ready(u0_crr), .consumer_read_data(u0_crd),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd), .consumer_write_ready(u0_cwr),
    .mem_read_valid(u0_mrv), .mem_read_address(u0_mra), .mem_read_ready(m0_rr), .mem_read_data(m0_rd),
    .mem_write_valid(u0_mwv), .mem_write_address(u0_mwa), .mem_write_data(u0_mwd), .mem_write_ready(m0_wr)
  );
  mem_controller_rr #(.NUM_CHANNELS(2)) u1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra), .consumer_read_ready(u1_crr), .consumer_read_data(u1_crd),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd), .consumer_write_ready(u1_cwr),
    .mem_read_valid(u1_mrv), .mem_read_address(u1_mra), .mem_read_ready(m1_rr), .mem_read_data(m1_rd),
    .mem_write_valid(u1_mwv), .mem_write_address(u1_mwa), .mem_write_data(u1_mwd), .mem_write_ready(m1_wr)
  );
  mem_controller_rr #(.WRITE_ENABLE(0)) u2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra), .consumer_read_ready(u2_crr), .consumer_read_data(u2_crd),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd), .consumer_write_ready(u2_cwr),
    .mem_read_valid(u2_mrv), .mem_read_address(u2_mra), .mem_read_ready(m0_rr), .mem_read_data(m0_rd),
    .mem_write_valid(u2_mwv), .mem_write_address(u2_mwa), .mem_write_data(u2_mwd), .mem_write_ready(m0_wr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    m0_rr = '0; m0_wr = '0; m0_rd = '0;
    m1_rr = '0; m1_wr = '0; m1_rd = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_mrv", u0_mrv, 0);
    chk("rst_crr", u0_crr, 0);
    chk("rst_mwv", u0_mwv, 0);
    reset = 1'b0;
    tick;
    ra[2] = 8'h15; rv[2] = 1'b1;
    tick;
    chk("t1_mrv", u0_mrv, 1);
    chk("t1_mra", u0_mra[0], 8'h15);
    chk("t1_crr_early", u0_crr, 0);
    m0_rr = 1'b1; m0_rd[0] = 16'hBEEF;
    tick;
    m0_rr = 1'b0;
    chk("t1_mrv_drop", u0_mrv, 0);
    chk("t1_crr", u0_crr, 4'b0100);
    chk("t1_data", u0_crd[2], 16'hBEEF);
    tick;
    chk("t1_hold", u0_crr, 4'b0100);
    rv[2] = 1'b0;
    tick;
    chk("t1_release", u0_crr, 0);
    do_reset;
    ra = {8'h30, 8'h20, 8'h10, 8'h00};
    rv = 4'hF;
    for (int r = 0; r < 5; r++) begin
      e = r % 4;
      tick;
      chk($sformatf("t2_addr_r%0d", r), u0_mra[0], 32'(e * 16));
      m0_rr = 1'b1; m0_rd[0] = 16'(e);
      tick;
      m0_rr = 1'b0;
      chk($sformatf("t2_ready_r%0d", r), u0_crr, 32'(1 << e));
      rv[e] = 1'b0;
      tick;
      rv[e] = 1'b1;
    end
    do_reset;
    ra[1] = 8'h11; ra[3] = 8'h33; rv = 4'b1010;
    tick;
    chk("t3_mrv", u1_mrv, 2'b11);
    chk("t3_mra0", u1_mra[0], 8'h11);
    chk("t3_mra1", u1_mra[1], 8'h33);
    m1_rr = 2'b11; m1_rd[0] = 16'h1111; m1_rd[1] = 16'h3333;
    tick;
    m1_rr = '0;
    chk("t3_crr", u1_crr, 4'b1010);
    chk("t3_data1", u1_crd[1], 16'h1111);
    chk("t3_data3", u1_crd[3], 16'h3333);
    rv = '0;
    tick;
    chk("t3_release", u1_crr, 0);
    do_reset;
    wa[1] = 8'h40; wd[1] = 16'h00A5; wv[1] = 1'b1;
    tick;
    chk("t4_mwv", u0_mwv, 1);
    chk("t4_mwa", u0_mwa[0], 8'h40);
    chk("t4_mwd", u0_mwd[0], 16'h00A5);
    chk("t4_mrv", u0_mrv, 0);
    m0_wr = 1'b1;
    tick;
    m0_wr = 1'b0;
    chk("t4_mwv_drop", u0_mwv, 0);
    chk("t4_cwr", u0_cwr, 4'b0010);
    wv[1] = 1'b0;
    tick;
    chk("t4_cwr_release", u0_cwr, 0);
    ra[1] = 8'h40; rv[1] = 1'b1;
    tick;
    chk("t4_read_mrv", u0_mrv, 1);
    chk("t4_read_mra", u0_mra[0], 8'h40);
    do_reset;
    ra[3] = 8'h77; rv[3] = 1'b1; wv[3] = 1'b1;
    tick;
    chk("t4_prio_mrv", u0_mrv, 1);
    chk("t4_prio_mwv", u0_mwv, 0);
    do_reset;
    wa[0] = 8'h12; wd[0] = 16'h5A5A; wv = 4'b0001; m0_wr = 1'b1;
    seen_mwv = 1'b0; seen_cwr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      seen_mwv = seen_mwv | u2_mwv[0];
      seen_cwr = seen_cwr | (|u2_cwr);
    end
    chk("t5_no_mwv", seen_mwv, 0);
    chk("t5_no_cwr", seen_cwr, 0);
    do_reset;
    ra[0] = 8'hA0; ra[1] = 8'hB1; rv = 4'b0001;
    tick;
    chk("t6_waiting", u0_mrv, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_mrv", u0_mrv, 0);
    chk("t6_async_mra", u0_mra[0], 0);
    rv = 4'b0011;
    reset = 1'b0;
    tick;
    chk("t6_regrant", u0_mra[0], 8'hA0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
